// File: rtl/mem_sweep_pkg.sv
// mem_sweep_pkg: shared mode encoding and controller state types for mem_sweep.
package mem_sweep_pkg;
    typedef enum logic [1:0] {
        MODE_FILL = 2'b00,
        MODE_COPY = 2'b01,
        MODE_CMP  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_e;
endpackage

// File: rtl/mem_sweep_if.sv
// mem_sweep_if: request/status and dual-port RAM bus of the sweep engine.
//   master: the engine (drives RAM enables/addresses/data and status)
//   slave : requester plus RAM (drives request fields and read data)
interface mem_sweep_if #(
    parameter int DW = 32,
    parameter int AW = 9
) ();
    import mem_sweep_pkg::*;
    logic            start;
    mode_e           mode;
    logic [AW-1:0]   base_src;
    logic [AW-1:0]   base_dst;
    logic [AW:0]     len;
    logic [DW-1:0]   fill;
    logic            en0;
    logic [AW-1:0]   a0;
    logic [DW-1:0]   do0;
    logic            en1;
    logic [AW-1:0]   a1;
    logic [DW/8-1:0] we1;
    logic [DW-1:0]   di1;
    logic [DW-1:0]   do1;
    logic            busy;
    logic            done;
    logic [AW:0]     mismatch_cnt;
    logic [AW-1:0]   first_mismatch;
    modport master (
        input  start, mode, base_src, base_dst, len, fill, do0, do1,
        output en0, a0, en1, a1, we1, di1, busy, done, mismatch_cnt, first_mismatch
    );
    modport slave (
        output start, mode, base_src, base_dst, len, fill, do0, do1,
        input  en0, a0, en1, a1, we1, di1, busy, done, mismatch_cnt, first_mismatch
    );
endinterface

// File: rtl/mem_sweep_agen.sv
// mem_sweep_agen: per-port word address generator.
//   ld_i/base_i/len_i : load start address and word count
//   step_i            : advance to the next word (wraps modulo 2**AW)
//   addr_o            : registered current word address
//   last_o            : current address is the final word of the sweep
module mem_sweep_agen #(
    parameter int AW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW:0]   len_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);
    logic [AW-1:0] addr_q;
    logic [AW:0]   rem_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else if (ld_i) begin
            addr_q <= base_i;
            rem_q  <= len_i - (AW+1)'(1);
        end else if (step_i) begin
            addr_q <= addr_q + AW'(1);
            rem_q  <= rem_q - (AW+1)'(1);
        end
    end
    assign addr_o = addr_q;
    assign last_o = rem_q == '0;
endmodule

// File: rtl/mem_sweep.sv
// mem_sweep: FILL / COPY / COMPARE sweep engine over a dual-port RAM.
//   clk, rst : clock, synchronous active-high reset
//   bus      : request fields, port-0 read bus, port-1 read/write bus, status
module mem_sweep import mem_sweep_pkg::*; #(
    parameter int DW = 32,
    parameter int AW = 9
) (
    input logic        clk,
    input logic        rst,
    mem_sweep_if.master bus
);
    state_e          state_q, state_d;
    mode_e           mode_q, mode_d;
    logic [DW-1:0]   fill_q;
    logic            busy_q, busy_d, done_q, done_d;
    logic            en0_q, en0_d, en1_q, en1_d;
    logic [DW/8-1:0] we1_q, we1_d;
    logic            rd_v_q;
    logic [AW-1:0]   cmp_idx_q, first_q;
    logic [AW:0]     mm_cnt_q;
    logic            accept, last0, last1, last_sel;
    assign accept = bus.start && state_q == S_IDLE && bus.mode != MODE_RSVD;
    mem_sweep_agen #(.AW(AW)) u_ag0 (
        .clk(clk), .rst(rst), .ld_i(accept), .base_i(bus.base_src), .len_i(bus.len),
        .step_i(en0_q), .addr_o(bus.a0), .last_o(last0)
    );
    mem_sweep_agen #(.AW(AW)) u_ag1 (
        .clk(clk), .rst(rst), .ld_i(accept), .base_i(bus.base_dst), .len_i(bus.len),
        .step_i(en1_q), .addr_o(bus.a1), .last_o(last1)
    );
    always_comb begin
        mode_d   = accept ? bus.mode : mode_q;
        last_sel = mode_q == MODE_FILL ? last1 : last0;
        state_d  = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? (bus.len == '0 ? S_DONE : S_RUN) : S_IDLE;
            S_RUN:   state_d = last_sel ? (mode_q == MODE_FILL ? S_DONE : S_DRAIN) : S_RUN;
            S_DRAIN: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        busy_d = state_d != S_IDLE;
        done_d = state_d == S_DONE;
        en0_d  = state_d == S_RUN && mode_d != MODE_FILL;
        // COPY writes each word one cycle after it was read on port 0
        en1_d  = mode_d == MODE_COPY ? en0_q : state_d == S_RUN;
        we1_d  = (en1_d && mode_d != MODE_CMP) ? '1 : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            mode_q    <= MODE_FILL;
            fill_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            en0_q     <= 1'b0;
            en1_q     <= 1'b0;
            we1_q     <= '0;
            rd_v_q    <= 1'b0;
            cmp_idx_q <= '0;
            mm_cnt_q  <= '0;
            first_q   <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            if (accept)
                fill_q <= bus.fill;
            busy_q <= busy_d;
            done_q <= done_d;
            en0_q  <= en0_d;
            en1_q  <= en1_d;
            we1_q  <= we1_d;
            // read data for a compare issued this cycle arrives next cycle
            rd_v_q <= en0_q && en1_q && mode_q == MODE_CMP;
            if (accept) begin
                cmp_idx_q <= '0;
                mm_cnt_q  <= '0;
                first_q   <= '1;
            end else if (rd_v_q) begin
                cmp_idx_q <= cmp_idx_q + AW'(1);
                if (bus.do0 != bus.do1) begin
                    mm_cnt_q <= mm_cnt_q + (AW+1)'(1);
                    if (mm_cnt_q == '0)
                        first_q <= cmp_idx_q;
                end
            end
        end
    end
    assign bus.en0            = en0_q;
    assign bus.en1            = en1_q;
    assign bus.we1            = we1_q;
    // COPY forwards the port-0 read word straight to port-1 in the write cycle
    assign bus.di1            = mode_q == MODE_FILL ? fill_q : bus.do0;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.mismatch_cnt   = mm_cnt_q;
    assign bus.first_mismatch = first_q;
endmodule

// File: tb/tb_mem_sweep.sv
// tb_mem_sweep: self-checking bench for mem_sweep with a behavioural RAM and reference model.
module tb_mem_sweep;
    import mem_sweep_pkg::*;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int N  = 512;
    typedef struct {
        int          mode;
        int          src;
        int          dst;
        int          len;
        logic [31:0] fill;
        int          prep;
        int          exp_done;
        int          exp_cnt;
        int          exp_first;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mem_sweep_if #(.DW(DW), .AW(AW)) bus ();
    mem_sweep #(.DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
    logic [31:0] mem     [N];
    logic [31:0] ref_mem [N];
    logic        bd_we = 1'b0;
    logic [8:0]  bd_a  = '0;
    logic [31:0] bd_d  = '0;
    int checks = 0;
    int fails  = 0;
    int model_cnt = 0;
    int model_first = 0;
    always @(posedge clk) begin
        if (bus.en0) bus.do0 <= mem[bus.a0];
        if (bus.en1) begin
            bus.do1 <= mem[bus.a1];
            for (int b = 0; b < 4; b++)
                if (bus.we1[b]) mem[bus.a1][8*b +: 8] <= bus.di1[8*b +: 8];
        end
        if (bd_we) mem[bd_a] <= bd_d;
    end
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic poke(input int a, input logic [31:0] d);
        bd_we = 1'b1;
        bd_a  = 9'(a);
        bd_d  = d;
        ref_mem[a % N] = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask
    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction
    // word-by-word reference semantics of one accepted request
    task automatic model_op(input int mode, input int s, input int d, input int len, input logic [31:0] fill);
        if (mode == 3) return;
        model_cnt   = 0;
        model_first = N - 1;
        for (int i = 0; i < len; i++) begin
            if (mode == 0) ref_mem[(d + i) % N] = fill;
            else if (mode == 1) ref_mem[(d + i) % N] = ref_mem[(s + i) % N];
            else if (ref_mem[(s + i) % N] != ref_mem[(d + i) % N]) begin
                if (model_cnt == 0) model_first = i;
                model_cnt++;
            end
        end
    endtask
    // entered and left at a falling edge; exp_cnt < 0 selects the model's mismatch result
    task automatic run_op(input int mode, input int s, input int d, input int len, input logic [31:0] fill,
                          input bit inject, input int exp_done, input int exp_cnt, input int exp_first,
                          input string tag);
        int  k, done_at = 0, busy_n = 0, e0 = 0, e1 = 0, wr = 0;
        bit  acc = mode != 3;
        int  budget = acc ? len + 10 : 6;
        bus.start = 1'b1;
        bus.mode = mode_e'(2'(mode));
        bus.base_src = 9'(s);
        bus.base_dst = 9'(d);
        bus.len = 10'(len);
        bus.fill = fill;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mode = mode_e'(2'($urandom));
        bus.base_src = 9'($urandom);
        bus.base_dst = 9'($urandom);
        bus.len = 10'($urandom);
        bus.fill = $urandom;
        model_op(mode, s, d, len, fill);
        for (k = 1; k <= budget; k++) begin
            if (bus.busy) busy_n++;
            if (bus.en0) e0++;
            if (bus.en1) e1++;
            if (bus.en1 && bus.we1 != 0) wr++;
            if (bus.done && done_at == 0) done_at = k;
            if (inject && k == 3) begin
                bus.start = 1'b1;
                bus.mode = MODE_FILL;
                bus.len = 10'd4;
            end
            if (inject && k == 4) bus.start = 1'b0;
            if (done_at != 0) break;
            @(negedge clk);
        end
        @(negedge clk);
        check({tag, ".done_cycle"}, done_at, exp_done);
        check({tag, ".busy_cycles"}, busy_n, acc ? exp_done : 0);
        check({tag, ".idle_after"}, {bus.busy, bus.done, bus.en0, bus.en1}, 0);
        check({tag, ".en0_cycles"}, e0, (acc && mode != 0) ? len : 0);
        check({tag, ".en1_cycles"}, e1, acc ? len : 0);
        check({tag, ".writes"}, wr, (acc && mode != 2) ? len : 0);
        check({tag, ".mismatch_cnt"}, bus.mismatch_cnt, exp_cnt < 0 ? model_cnt : exp_cnt);
        check({tag, ".first_mismatch"}, bus.first_mismatch, exp_cnt < 0 ? model_first : exp_first);
        check({tag, ".mem_diffs"}, mem_diffs(), 0);
    endtask
    vec_t tv [9];
    int   picks [4] = '{'h000, 'h020, 'h0E0, 'h1F0};
    initial begin
        tv[0] = '{0, 'h000, 'h1F0, 32, 32'hDEADBEEF, 0, 33, 0, 'h1FF};
        tv[1] = '{1, 'h010, 'h100, 8, 32'h0, 1, 10, 0, 'h1FF};
        tv[2] = '{2, 'h040, 'h140, 16, 32'h0, 2, 18, 2, 3};
        tv[3] = '{3, 'h040, 'h140, 16, 32'h0, 0, 0, 2, 3};
        tv[4] = '{2, 'h040, 'h140, 0, 32'h0, 0, 1, 0, 'h1FF};
        tv[5] = '{0, 'h000, 'h000, 0, 32'h12345678, 0, 1, 0, 'h1FF};
        tv[6] = '{2, 'h040, 'h140, 16, 32'h0, 3, 18, 0, 'h1FF};
        tv[7] = '{1, 'h1FC, 'h0FC, 8, 32'h0, 0, 10, 0, 'h1FF};
        tv[8] = '{0, 'h000, 'h123, 512, 32'hA5A5A5A5, 0, 513, 0, 'h1FF};
        bus.start = 1'b0;
        bus.mode = MODE_FILL;
        bus.base_src = '0;
        bus.base_dst = '0;
        bus.len = '0;
        bus.fill = '0;
        @(negedge clk);
        for (int i = 0; i < N; i++) poke(i, $urandom);
        check("reset.busy_done", {bus.busy, bus.done}, 0);
        check("reset.enables", {bus.en0, bus.en1, bus.we1}, 0);
        check("reset.addrs", {bus.a0, bus.a1}, 0);
        check("reset.di1", bus.di1, 0);
        check("reset.mismatch_cnt", bus.mismatch_cnt, 0);
        check("reset.first_mismatch", bus.first_mismatch, 0);
        bus.start = 1'b1;
        bus.len = 10'd4;
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("start_in_rst.busy", {bus.busy, bus.en1}, 0);
        for (int r = 0; r < 9; r++) begin
            for (int i = 0; i < 16; i++) begin
                logic [31:0] v = $urandom;
                if (tv[r].prep == 1 && i < 8) poke(tv[r].src + i, 32'(i + 1));
                if (tv[r].prep >= 2) begin
                    poke(tv[r].src + i, v);
                    poke(tv[r].dst + i, (tv[r].prep == 2 && (i == 3 || i == 9)) ? v ^ 32'h100 : v);
                end
            end
            run_op(tv[r].mode, tv[r].src, tv[r].dst, tv[r].len, tv[r].fill, 1'b0,
                   tv[r].exp_done, tv[r].exp_cnt, tv[r].exp_first, $sformatf("vec%0d", r));
            if (r == 0) begin
                check("fill_wrap.mem1FF", mem['h1FF], 32'hDEADBEEF);
                check("fill_wrap.mem00F", mem['h00F], 32'hDEADBEEF);
            end
            if (tv[r].prep == 1)
                for (int i = 0; i < 8; i++) check($sformatf("copy.dst%0d", i), mem['h100 + i], i + 1);
        end
        run_op(1, 'h020, 'h120, 8, 32'h0, 1'b1, 10, 0, 'h1FF, "start_while_busy");
        begin
            int seen = 0;
            for (int i = 0; i < 20; i++) poke('h080 + i, $urandom);
            bus.start = 1'b1;
            bus.mode = MODE_COPY;
            bus.base_src = 9'h080;
            bus.base_dst = 9'h180;
            bus.len = 10'd20;
            @(negedge clk);
            bus.start = 1'b0;
            for (int k = 1; k < 4; k++) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check("abort.outputs", {bus.busy, bus.done, bus.en0, bus.en1, bus.we1}, 0);
            check("abort.mismatch", {bus.mismatch_cnt, bus.first_mismatch}, 0);
            rst = 1'b0;
            for (int k = 0; k < 25; k++) begin
                @(negedge clk);
                if (bus.done || bus.busy || bus.en0 || bus.en1) seen++;
            end
            check("abort.quiet", seen, 0);
            for (int i = 0; i < 3; i++) ref_mem['h180 + i] = ref_mem['h080 + i];
            model_cnt = 0;
            model_first = 0;
            check("abort.mem_diffs", mem_diffs(), 0);
        end
        run_op(0, 'h000, 'h180, 4, 32'hCAFEF00D, 1'b0, 5, 0, 'h1FF, "after_abort");
        for (int t = 0; t < 25; t++) begin
            int m = $urandom_range(0, 3);
            int s = picks[$urandom_range(0, 3)];
            int l = $urandom_range(0, 40);
            int ed = m == 3 ? 0 : l == 0 ? 1 : m == 0 ? l + 1 : l + 2;
            run_op(m, s, (s + 256) % N, l, $urandom, 1'b0, ed, -1, 0, $sformatf("rnd%0d", t));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
